// File: rtl/ahb_bram_bank_bridge.sv
// rtl/ahb_bram_bank_bridge.sv - AHB-Lite slave fronting banked single-port BRAMs
// Wait-stated reads, byte/half/word write strobes, two-cycle ERROR on illegal transfers.
module ahb_bram_bank_bridge #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BANKS  = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HSEL,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  input  logic [2:0]                HSIZE,
  input  logic                      HWRITE,
  input  logic [31:0]               HWDATA,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic [31:0]               HRDATA,
  output logic                      HRESP,
  output logic [NUM_BANKS-1:0]      BRAM_EN,
  output logic [ADDR_WIDTH-1:0]     BRAM_ADDR,
  output logic [3:0]                BRAM_WE,
  output logic [31:0]               BRAM_WDATA,
  input  logic [32*NUM_BANKS-1:0]   BRAM_RDATA
);

  localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]            state;
  logic [1:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BANK_BITS-1:0]  bank_q;
  logic [3:0]            strb_q;

  logic [BANK_BITS-1:0]  req_bank;
  logic [3:0]            req_strb;
  logic                  req_legal;
  logic                  rd_done;
  logic                  can_accept;
  logic                  accept;
  logic [NUM_BANKS-1:0]  bank_onehot;
  logic [31:0]           bank_rdata;
  logic                  unused_bits;

  assign req_bank    = HADDR[ADDR_WIDTH+2 +: BANK_BITS];
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2+BANK_BITS], HTRANS[0]};

  // An all-zero strobe marks a size/alignment combination that is not supported.
  always_comb begin
    req_strb = 4'h0;
    case ({HADDR[1:0], HSIZE})
      5'b00_000: req_strb = 4'b0001;
      5'b01_000: req_strb = 4'b0010;
      5'b10_000: req_strb = 4'b0100;
      5'b11_000: req_strb = 4'b1000;
      5'b00_001: req_strb = 4'b0011;
      5'b10_001: req_strb = 4'b1100;
      5'b00_010: req_strb = 4'b1111;
      default:   req_strb = 4'h0;
    endcase
    req_legal = (req_strb != 4'h0) && (32'(req_bank) < 32'(NUM_BANKS));
  end

  assign rd_done    = (state == S_RD) && (cnt == LAT);
  assign can_accept = (state == S_IDLE) || (state == S_WR) || rd_done || (state == S_ERR2);
  assign accept     = HSEL && HTRANS[1] && HREADY && can_accept;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= S_IDLE;
      cnt    <= 2'd0;
      addr_q <= '0;
      bank_q <= '0;
      strb_q <= 4'h0;
    end else if (accept) begin
      addr_q <= HADDR[ADDR_WIDTH+1:2];
      bank_q <= req_bank;
      strb_q <= req_strb;
      cnt    <= 2'd0;
      state  <= !req_legal ? S_ERR1 : (HWRITE ? S_WR : S_RD);
    end else begin
      case (state)
        S_RD: begin
          if (rd_done) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_ERR1:  state <= S_ERR2;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bank_onehot = '0;
    bank_rdata  = 32'h0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_q == BANK_BITS'(i)) begin
        bank_onehot[i] = 1'b1;
        bank_rdata     = BRAM_RDATA[32*i +: 32];
      end
    end
  end

  // The BRAM is touched only in the first data-phase cycle of a legal transfer.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0;
    BRAM_EN   = '0;
    BRAM_WE   = 4'h0;
    case (state)
      S_WR: begin
        BRAM_EN = bank_onehot;
        BRAM_WE = strb_q;
      end
      S_RD: begin
        if (cnt == 2'd0) BRAM_EN = bank_onehot;
        HREADYOUT = rd_done;
        if (rd_done) HRDATA = bank_rdata;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  assign BRAM_ADDR  = addr_q;
  assign BRAM_WDATA = HWDATA;

endmodule

// File: tb/tb_ahb_bram_bank_bridge.sv
// tb/tb_ahb_bram_bank_bridge.sv - table-driven bench for ahb_bram_bank_bridge
module tb_ahb_bram_bank_bridge;

  localparam int AW  = 10;
  localparam int NB  = 3;
  localparam int RDL = 2;

  logic          HCLK = 1'b0;
  logic          HRESET, HSEL, HWRITE, HREADY;
  logic [31:0]   HADDR, HWDATA;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HREADYOUT, HRESP;
  logic [31:0]   HRDATA, BRAM_WDATA;
  logic [NB-1:0] BRAM_EN;
  logic [AW-1:0] BRAM_ADDR;
  logic [3:0]    BRAM_WE;
  logic [32*NB-1:0] BRAM_RDATA;

  always #5 HCLK = ~HCLK;

  ahb_bram_bank_bridge #(.ADDR_WIDTH(AW), .NUM_BANKS(NB), .RD_LATENCY(RDL)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .BRAM_EN(BRAM_EN),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_WE(BRAM_WE), .BRAM_WDATA(BRAM_WDATA),
    .BRAM_RDATA(BRAM_RDATA)
  );

  // BRAM model: byte-strobed writes, RDL-stage read pipe; junk when no read was issued.
  logic [31:0] mem  [NB][1<<AW];
  logic [31:0] pipe [NB][RDL];

  always @(posedge HCLK) begin
    for (int b = 0; b < NB; b++) begin
      if (BRAM_EN[b])
        for (int k = 0; k < 4; k++)
          if (BRAM_WE[k]) mem[b][BRAM_ADDR][8*k +: 8] <= BRAM_WDATA[8*k +: 8];
      pipe[b][0] <= (BRAM_EN[b] && BRAM_WE == 4'h0) ? mem[b][BRAM_ADDR] : (32'hBAD0_0000 | 32'(b));
      for (int s = 1; s < RDL; s++) pipe[b][s] <= pipe[b][s-1];
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_rd
    assign BRAM_RDATA[32*g +: 32] = pipe[g][RDL-1];
  end

  typedef struct {
    logic          sel;
    logic [1:0]    trans;
    logic [31:0]   addr;
    logic [2:0]    size;
    logic          wr;
    logic [31:0]   wdata;
    logic          rdy_in;
    logic          e_rdy;
    logic          e_resp;
    logic [31:0]   e_rdata;
    logic [NB-1:0] e_en;
    logic [3:0]    e_we;
    logic [AW-1:0] e_baddr;
  } vec_t;

  vec_t vt[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic [31:0] sel, logic [31:0] trans, logic [31:0] addr,
                              logic [31:0] size, logic [31:0] wr, logic [31:0] wdata,
                              logic [31:0] rdy_in, logic [31:0] e_rdy, logic [31:0] e_resp,
                              logic [31:0] e_rdata, logic [31:0] e_en, logic [31:0] e_we,
                              logic [31:0] e_baddr);
    vec_t v;
    v.sel = sel[0];       v.trans = trans[1:0]; v.addr = addr;     v.size = size[2:0];
    v.wr = wr[0];         v.wdata = wdata;      v.rdy_in = rdy_in[0];
    v.e_rdy = e_rdy[0];   v.e_resp = e_resp[0]; v.e_rdata = e_rdata;
    v.e_en = e_en[NB-1:0]; v.e_we = e_we[3:0];  v.e_baddr = e_baddr[AW-1:0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic resp, input logic [31:0] rdata,
                         input logic [NB-1:0] en, input logic [3:0] we, input logic [AW-1:0] baddr);
    chk({tag, " hreadyout"}, 32'(HREADYOUT), 32'(rdy));
    chk({tag, " hresp"},     32'(HRESP),     32'(resp));
    chk({tag, " hrdata"},    HRDATA,         rdata);
    chk({tag, " bram_en"},   32'(BRAM_EN),   32'(en));
    chk({tag, " bram_we"},   32'(BRAM_WE),   32'(we));
    chk({tag, " bram_addr"}, 32'(BRAM_ADDR), 32'(baddr));
  endtask

  task automatic drive(input vec_t v);
    HSEL = v.sel; HTRANS = v.trans; HADDR = v.addr; HSIZE = v.size;
    HWRITE = v.wr; HWDATA = v.wdata; HREADY = v.rdy_in;
  endtask

  initial begin
    int n;
    // sel trans addr size wr wdata rdy_in | rdy resp rdata en we baddr
    // word write bank1 word5, then pipelined read of it
    vt.push_back(mk(1, 2, 'h1014, 2, 1, 0,           1, 1, 0, 0,           'b000, 0, 0));
    vt.push_back(mk(1, 2, 'h1014, 2, 0, 'hDEADBEEF,  1, 1, 0, 0,           'b010, 'hF, 5));
    vt.push_back(mk(0, 0, 0,      0, 0, 0,           0, 0, 0, 0,           'b010, 0, 5));
    vt.push_back(mk(0, 0, 0,      0, 0, 0,           0, 0, 0, 0,           'b000, 0, 5));
    vt.push_back(mk(0, 0, 0,      0, 0, 0,           1, 1, 0, 'hDEADBEEF,  'b000, 0, 5));
    // byte lanes into bank0 word0, then word read
    vt.push_back(mk(1, 2, 'h0,    0, 1, 0,           1, 1, 0, 0,           'b000, 0, 5));
    vt.push_back(mk(1, 2, 'h1,    0, 1, 'h11,        1, 1, 0, 0,           'b001, 1, 0));
    vt.push_back(mk(1, 2, 'h2,    0, 1, 'h2200,      1, 1, 0, 0,           'b001, 2, 0));
    vt.push_back(mk(1, 2, 'h3,    0, 1, 'h330000,    1, 1, 0, 0,           'b001, 4, 0));
    vt.push_back(mk(1, 2, 'h0,    2, 0, 'h44000000,  1, 1, 0, 0,           'b001, 8, 0));
    vt.push_back(mk(0, 0, 0,      0, 0, 0,           0, 0, 0, 0,           'b001, 0, 0));
    vt.push_back(mk(0, 0, 0,      0, 0, 0,           0, 0, 0, 0,           'b000, 0, 0));
    vt.push_back(mk(0, 0, 0,      0, 0, 0,           1, 1, 0, 'h44332211,  'b000, 0, 0));
    // misaligned halfword, then bank 3 (out of range) accepted during ERR2
    vt.push_back(mk(1, 2, 'h1,    1, 0, 0,           1, 1, 0, 0,           'b000, 0, 0));
    vt.push_back(mk(0, 0, 0,      0, 0, 0,           0, 0, 1, 0,           'b000, 0, 0));
    vt.push_back(mk(1, 2, 'h3000, 2, 1, 0,           1, 1, 1, 0,           'b000, 0, 0));
    vt.push_back(mk(0, 0, 0,      0, 0, 'h55555555,  0, 0, 1, 0,           'b000, 0, 0));
    vt.push_back(mk(0, 0, 0,      0, 0, 0,           1, 1, 1, 0,           'b000, 0, 0));
    // back-to-back write, read (address held through wait states), write, read
    vt.push_back(mk(1, 2, 'h201C, 2, 1, 0,           1, 1, 0, 0,           'b000, 0, 0));
    vt.push_back(mk(1, 2, 'h1014, 2, 0, 'hCAFEF00D,  1, 1, 0, 0,           'b100, 'hF, 7));
    vt.push_back(mk(1, 2, 'h000C, 2, 1, 0,           0, 0, 0, 0,           'b010, 0, 5));
    vt.push_back(mk(1, 2, 'h000C, 2, 1, 0,           0, 0, 0, 0,           'b000, 0, 5));
    vt.push_back(mk(1, 2, 'h000C, 2, 1, 0,           1, 1, 0, 'hDEADBEEF,  'b000, 0, 5));
    vt.push_back(mk(1, 2, 'h201C, 2, 0, 'h12345678,  1, 1, 0, 0,           'b001, 'hF, 3));
    vt.push_back(mk(0, 0, 0,      0, 0, 0,           0, 0, 0, 0,           'b100, 0, 7));
    vt.push_back(mk(0, 0, 0,      0, 0, 0,           0, 0, 0, 0,           'b000, 0, 7));
    vt.push_back(mk(0, 0, 0,      0, 0, 0,           1, 1, 0, 'hCAFEF00D,  'b000, 0, 7));
    // IDLE, BUSY, HSEL=0, HREADY=0 address phases are ignored
    vt.push_back(mk(1, 0, 'h000C, 2, 1, 0,           1, 1, 0, 0,           'b000, 0, 7));
    vt.push_back(mk(1, 1, 'h000C, 2, 1, 0,           1, 1, 0, 0,           'b000, 0, 7));
    vt.push_back(mk(0, 2, 'h000C, 2, 1, 0,           1, 1, 0, 0,           'b000, 0, 7));
    vt.push_back(mk(1, 2, 'h000C, 2, 1, 0,           0, 1, 0, 0,           'b000, 0, 7));
    vt.push_back(mk(0, 0, 0,      0, 0, 0,           1, 1, 0, 0,           'b000, 0, 7));
    vt.push_back(mk(1, 2, 'h000C, 2, 0, 0,           1, 1, 0, 0,           'b000, 0, 7));
    vt.push_back(mk(0, 0, 0,      0, 0, 0,           0, 0, 0, 0,           'b001, 0, 3));
    vt.push_back(mk(0, 0, 0,      0, 0, 0,           0, 0, 0, 0,           'b000, 0, 3));
    vt.push_back(mk(0, 0, 0,      0, 0, 0,           1, 1, 0, 'h12345678,  'b000, 0, 3));

    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0; HSIZE = 3'd0;
    HWRITE = 1'b0; HWDATA = 32'h0; HREADY = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    @(negedge HCLK);
    chk_all("reset", 1'b1, 1'b0, 32'h0, 3'b000, 4'h0, 10'd0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      @(negedge HCLK);
      chk_all($sformatf("row%0d", i), vt[i].e_rdy, vt[i].e_resp, vt[i].e_rdata,
              vt[i].e_en, vt[i].e_we, vt[i].e_baddr);
      @(posedge HCLK);
      #1;
    end

    // reset in the first read wait cycle, then a clean read
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h1014; HSIZE = 3'd2; HWRITE = 1'b0; HREADY = 1'b1;
    @(posedge HCLK);
    #1;
    HTRANS = 2'b00; HREADY = 1'b0; HRESET = 1'b1;
    @(negedge HCLK);
    chk("rst_mid en", 32'(BRAM_EN), 32'b010);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0; HTRANS = 2'b10; HADDR = 32'h1014; HREADY = 1'b1;
    @(negedge HCLK);
    chk_all("after_rst", 1'b1, 1'b0, 32'h0, 3'b000, 4'h0, 10'd0);
    @(posedge HCLK);
    #1;
    HTRANS = 2'b00; HREADY = 1'b0;
    n = 1;
    @(negedge HCLK);
    while (!HREADYOUT && n < 10) begin
      @(posedge HCLK);
      #1;
      @(negedge HCLK);
      n++;
    end
    chk("post_rst read cycles", 32'(n), 32'(RDL + 1));
    chk("post_rst read data", HRDATA, 32'hDEADBEEF);
    @(posedge HCLK);
    #1;
    HREADY = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
